// File: rtl/led_pkg.sv
// led_pkg: shared constants for the LED pattern generator.
//   mode_e     - pattern select encodings (MODE_BLINK/CHASE/BOUNCE/COUNT)
//   dir_e      - bounce travel direction
//   PRESCALE_W - prescaler counter width, wide enough for any legal DIV
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned PRESCALE_W = 32;

endpackage

// File: rtl/tick_div.sv
// tick_div: step prescaler. Counts 0..DIV-1 while EN is high and flags the
// wrapping edge on TICK; holds while EN is low; CLR restarts it from zero.
//   CLOCK_50 - system clock (rising edge)
//   RESET    - asynchronous active-high reset
//   EN       - count enable
//   CLR      - synchronous clear, overrides EN and suppresses TICK
//   TICK     - high during the cycle whose rising edge wraps the counter
module tick_div
    import led_pkg::*;
#(
    parameter int unsigned DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(DIV - 1);

    logic [PRESCALE_W-1:0] count;

    // Combinational so the pattern register can step on the wrapping edge itself.
    assign TICK = EN && !CLR && (count == LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (EN) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: steps an LED pattern (blink, chase, bounce, count) once
// every DIV enabled clock cycles.
//   CLOCK_50 - system clock (rising edge)
//   RESET    - asynchronous active-high reset
//   EN       - step enable; low freezes prescaler and pattern
//   MODE     - pattern select (led_pkg::mode_e encoding)
//   LEDG     - registered LED pattern, WIDTH bits
//   STEP     - registered one-cycle pulse marking a stepped LEDG value
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 25000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] LEDG,
    output logic             STEP
);

    mode_e            mode_q;
    dir_e             dir_q;
    logic             mode_change_c;
    logic             tick_c;
    logic [WIDTH-1:0] next_ledg_c;
    dir_e             next_dir_c;

    // A pending mode change clears the prescaler and swallows a coincident tick.
    assign mode_change_c = (mode_e'(MODE) != mode_q);

    tick_div #(
        .DIV(DIV)
    ) u_tick_div (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .EN      (EN),
        .CLR     (mode_change_c),
        .TICK    (tick_c)
    );

    // Pattern loaded when a mode is entered.
    function automatic logic [WIDTH-1:0] init_pattern(input mode_e m);
        case (m)
            MODE_CHASE, MODE_BOUNCE: init_pattern = WIDTH'(1);
            default:                 init_pattern = '0;
        endcase
    endfunction

    // Next pattern and bounce direction for one step of the active mode.
    always_comb begin
        next_ledg_c = LEDG;
        next_dir_c  = dir_q;
        case (mode_q)
            MODE_BLINK: next_ledg_c = ~LEDG;
            MODE_CHASE: next_ledg_c = {LEDG[WIDTH-2:0], LEDG[WIDTH-1]};
            MODE_BOUNCE: begin
                // Flip on arrival at an end so the end position is not repeated.
                if (dir_q == DIR_LEFT) begin
                    next_ledg_c = LEDG << 1;
                    if (next_ledg_c[WIDTH-1]) begin
                        next_dir_c = DIR_RIGHT;
                    end
                end else begin
                    next_ledg_c = LEDG >> 1;
                    if (next_ledg_c[0]) begin
                        next_dir_c = DIR_LEFT;
                    end
                end
            end
            MODE_COUNT: next_ledg_c = LEDG + WIDTH'(1);
            default:    next_ledg_c = LEDG;
        endcase
    end

    // Mode register, pattern, direction and step pulse.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            mode_q <= MODE_BLINK;
            dir_q  <= DIR_LEFT;
            LEDG   <= '0;
            STEP   <= 1'b0;
        end else if (mode_change_c) begin
            mode_q <= mode_e'(MODE);
            dir_q  <= DIR_LEFT;
            LEDG   <= init_pattern(mode_e'(MODE));
            STEP   <= 1'b0;
        end else if (tick_c) begin
            dir_q  <= next_dir_c;
            LEDG   <= next_ledg_c;
            STEP   <= 1'b1;
        end else begin
            STEP   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: three instances (8/4, 4/1, 8/1 for WIDTH/DIV) share one
// stimulus stream; a closed-form reference (pattern as a function of step
// index since the last reload) feeds a scoreboard checked by a monitor.
module tb_led_pattern_gen;

    localparam int unsigned N = 3;
    localparam int unsigned WS[N] = '{8, 4, 8};
    localparam int unsigned DS[N] = '{4, 1, 1};

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       EN;
    logic [1:0] MODE;

    logic [7:0] ledg0;
    logic [3:0] ledg1;
    logic [7:0] ledg2;
    logic       step0, step1, step2;

    logic [31:0] act_ledg[N];
    logic        act_step[N];

    typedef struct packed {
        logic [N-1:0][31:0] ledg;
        logic [N-1:0]       step;
    } exp_t;

    exp_t sb_q[$];

    logic [1:0]  m_mode[N];
    int unsigned m_k[N];
    int unsigned m_cnt[N];
    logic        prev_rst;

    int total = 0;
    int bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    led_pattern_gen #(.WIDTH(8), .DIV(4)) u_dut0 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .EN(EN), .MODE(MODE),
        .LEDG(ledg0), .STEP(step0)
    );
    led_pattern_gen #(.WIDTH(4), .DIV(1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .EN(EN), .MODE(MODE),
        .LEDG(ledg1), .STEP(step1)
    );
    led_pattern_gen #(.WIDTH(8), .DIV(1)) u_dut2 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .EN(EN), .MODE(MODE),
        .LEDG(ledg2), .STEP(step2)
    );

    always_comb begin
        act_ledg[0] = 32'(ledg0);
        act_ledg[1] = 32'(ledg1);
        act_ledg[2] = 32'(ledg2);
        act_step[0] = step0;
        act_step[1] = step1;
        act_step[2] = step2;
    end

    function automatic logic [31:0] mask_w(input int unsigned w);
        mask_w = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // LED pattern after k steps from a mode's initial pattern.
    function automatic logic [31:0] pat(input logic [1:0] m, input int unsigned k,
                                        input int unsigned w);
        int unsigned period, p, pos;
        case (m)
            2'b00: pat = (k % 2 == 1) ? mask_w(w) : 32'd0;
            2'b01: pat = 32'd1 << (k % w);
            2'b10: begin
                period = 2 * (w - 1);
                p      = k % period;
                pos    = (p < w) ? p : (period - p);
                pat    = 32'd1 << pos;
            end
            default: pat = 32'(k) & mask_w(w);
        endcase
    endfunction

    // Drive one cycle of inputs, advance the reference, queue the expectation.
    task automatic cycle(input logic rst, input logic en, input logic [1:0] mode);
        exp_t e;
        @(negedge CLOCK_50);
        RESET = rst;
        EN    = en;
        MODE  = mode;
        for (int i = 0; i < int'(N); i++) begin
            e.step[i] = 1'b0;
            if (rst) begin
                m_mode[i] = 2'b00;
                m_k[i]    = 0;
                m_cnt[i]  = 0;
            end else if (mode != m_mode[i]) begin
                m_mode[i] = mode;
                m_k[i]    = 0;
                m_cnt[i]  = 0;
            end else if (en) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == DS[i]) begin
                    m_cnt[i]  = 0;
                    m_k[i]    = m_k[i] + 1;
                    e.step[i] = 1'b1;
                end
            end
            e.ledg[i] = pat(m_mode[i], m_k[i], WS[i]);
        end
        sb_q.push_back(e);
        if (rst && !prev_rst) begin
            #1;
            for (int i = 0; i < int'(N); i++) begin
                total++;
                if (act_ledg[i] !== 32'd0 || act_step[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL async_reset dut%0d t=%0t: got ledg=%h step=%b, want ledg=0 step=0",
                             i, $time, act_ledg[i], act_step[i]);
                end
            end
        end
        prev_rst = rst;
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] mode);
        for (int c = 0; c < n; c++) cycle(1'b0, en, mode);
    endtask

    // Monitor: compare each DUT against the queued expectation after every edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < int'(N); i++) begin
                    total++;
                    if (act_ledg[i] !== e.ledg[i] || act_step[i] !== e.step[i]) begin
                        bad++;
                        $display("FAIL ledg_step dut%0d t=%0t: got ledg=%h step=%b, want ledg=%h step=%b",
                                 i, $time, act_ledg[i], act_step[i], e.ledg[i], e.step[i]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [1:0] cur_mode;
        RESET    = 1'b1;
        EN       = 1'b0;
        MODE     = 2'b00;
        prev_rst = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            m_mode[i] = 2'b00;
            m_k[i]    = 0;
            m_cnt[i]  = 0;
        end

        repeat (3) cycle(1'b1, 1'b1, 2'b00);

        // Blink from reset: steps on edges 4 and 8 for DIV=4.
        run(10, 1'b1, 2'b00);
        // Chase through a full rotation and wrap.
        run(40, 1'b1, 2'b01);

        // Freeze with the DIV=4 prescaler at 2, then resume.
        for (int c = 0; c < 8 && m_cnt[0] != 2; c++) cycle(1'b0, 1'b1, 2'b01);
        run(10, 1'b0, 2'b01);
        run(6, 1'b1, 2'b01);

        // Mode change 00->01 on the edge that would tick.
        run(2, 1'b1, 2'b00);
        for (int c = 0; c < 8 && m_cnt[0] != DS[0] - 1; c++) cycle(1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        run(8, 1'b1, 2'b01);

        // Bounce, including end-point reversals.
        run(30, 1'b1, 2'b10);
        // Count long enough for the DIV=1 instance to wrap FF -> 00.
        run(300, 1'b1, 2'b11);

        // Reset mid-count, then release with a non-blink mode selected.
        cycle(1'b1, 1'b1, 2'b11);
        cycle(1'b1, 1'b1, 2'b11);
        run(12, 1'b1, 2'b11);

        // Randomized enable, mode and reset traffic.
        cur_mode = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39, 0) == 0) cur_mode = 2'($urandom_range(3, 0));
            cycle(($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
                  cur_mode);
        end
        run(2, 1'b1, cur_mode);

        repeat (2) @(posedge CLOCK_50);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
